// File: rtl/wb_dest_sequencer.sv
// Write-back sequencer: routes execute-stage results to the register file or PC,
// splitting long-multiply results into two ordered register writes.
module wb_dest_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [1:0]        res_dst,
  input  logic [DATA_W-1:0] res_lo,
  input  logic [DATA_W-1:0] res_hi,
  input  logic [REG_AW-1:0] rd_lo,
  input  logic [REG_AW-1:0] rd_hi,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ONE = 2'd1,
    WR_LO  = 2'd2,
    WR_HI  = 2'd3
  } state_t;

  localparam logic [REG_AW-1:0] PC_ADDR = {REG_AW{1'b1}};

  state_t              state, state_nxt;
  logic [REG_AW-1:0]   hi_addr, hi_addr_nxt;
  logic [DATA_W-1:0]   hi_data, hi_data_nxt;
  logic                rf_we_nxt, pc_we_nxt;
  logic [REG_AW-1:0]   rf_waddr_nxt;
  logic [DATA_W-1:0]   rf_wdata_nxt, pc_wdata_nxt;
  logic                wr_req, wr_pc;
  logic [REG_AW-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  assign res_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      hi_addr  <= '0;
      hi_data  <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pc_we    <= 1'b0;
      pc_wdata <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      hi_addr  <= hi_addr_nxt;
      hi_data  <= hi_data_nxt;
      rf_we    <= rf_we_nxt;
      rf_waddr <= rf_waddr_nxt;
      rf_wdata <= rf_wdata_nxt;
      pc_we    <= pc_we_nxt;
      pc_wdata <= pc_wdata_nxt;
    end
  end

  // The write for the upcoming state is chosen here so that the strobe
  // registered at the edge lines up exactly with the cycle spent in that state.
  always_comb begin
    state_nxt    = state;
    hi_addr_nxt  = hi_addr;
    hi_data_nxt  = hi_data;
    rf_we_nxt    = 1'b0;
    pc_we_nxt    = 1'b0;
    rf_waddr_nxt = rf_waddr;
    rf_wdata_nxt = rf_wdata;
    pc_wdata_nxt = pc_wdata;
    wr_req       = 1'b0;
    wr_pc        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;

    case (state)
      IDLE: begin
        if (res_valid) begin
          case (res_dst)
            2'b00: begin
              state_nxt = WR_ONE;
              wr_req    = 1'b1;
              wr_addr   = rd_lo;
              wr_data   = res_lo;
            end
            2'b01: begin
              state_nxt   = WR_LO;
              wr_req      = 1'b1;
              wr_addr     = rd_lo;
              wr_data     = res_lo;
              hi_addr_nxt = rd_hi;
              hi_data_nxt = res_hi;
            end
            2'b10: begin
              state_nxt = WR_ONE;
              wr_req    = 1'b1;
              wr_pc     = 1'b1;
              wr_data   = res_lo;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
      WR_LO: begin
        state_nxt = WR_HI;
        wr_req    = 1'b1;
        wr_addr   = hi_addr;
        wr_data   = hi_data;
      end
      WR_ONE:  state_nxt = IDLE;
      WR_HI:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Register 15 is the PC, so any write aimed there becomes a PC load.
    if (wr_req) begin
      if (wr_pc || (wr_addr == PC_ADDR)) begin
        pc_we_nxt    = 1'b1;
        pc_wdata_nxt = wr_data;
      end else begin
        rf_we_nxt    = 1'b1;
        rf_waddr_nxt = wr_addr;
        rf_wdata_nxt = wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_dest_sequencer.sv
// Bench for wb_dest_sequencer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the expected write stream.
module tb_wb_dest_sequencer;

  logic        clk;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_dst;
  logic [31:0] res_lo, res_hi;
  logic [3:0]  rd_lo, rd_hi;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic        busy;

  wb_dest_sequencer #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_dst(res_dst),
    .res_lo(res_lo), .res_hi(res_hi), .rd_lo(rd_lo), .rd_hi(rd_hi),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_we(pc_we), .pc_wdata(pc_wdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One pending write in the model: either a PC load or a register write.
  typedef struct {
    logic        to_pc;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         pend[$];
  wr_t         cur;
  logic        cur_valid;
  logic [3:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic [31:0] exp_pc_wdata;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic model_reset();
    pend.delete();
    cur_valid    = 1'b0;
    exp_waddr    = '0;
    exp_wdata    = '0;
    exp_pc_wdata = '0;
  endtask

  // Each accepted result expands into its list of writes; one write per cycle.
  task automatic model_edge(input logic acc, input logic [1:0] d, input logic [31:0] lo, input logic [31:0] hi,
                            input logic [3:0] rl, input logic [3:0] rh);
    wr_t w;
    if (cur_valid) begin
      if (pend.size() > 0) cur = pend.pop_front();
      else cur_valid = 1'b0;
    end else if (acc) begin
      if (d == 2'b00 || d == 2'b01) begin
        w.to_pc = (rl == 4'd15); w.addr = rl; w.data = lo; pend.push_back(w);
      end
      if (d == 2'b01) begin
        w.to_pc = (rh == 4'd15); w.addr = rh; w.data = hi; pend.push_back(w);
      end
      if (d == 2'b10) begin
        w.to_pc = 1'b1; w.addr = rl; w.data = lo; pend.push_back(w);
      end
      if (pend.size() > 0) begin
        cur = pend.pop_front();
        cur_valid = 1'b1;
      end
    end
    if (cur_valid) begin
      if (cur.to_pc) exp_pc_wdata = cur.data;
      else begin
        exp_waddr = cur.addr;
        exp_wdata = cur.data;
      end
    end
  endtask

  task automatic check_all(input string tag);
    checkOutput({tag, ".rf_we"},     {31'd0, rf_we},     {31'd0, cur_valid && !cur.to_pc});
    checkOutput({tag, ".pc_we"},     {31'd0, pc_we},     {31'd0, cur_valid && cur.to_pc});
    checkOutput({tag, ".rf_waddr"},  {28'd0, rf_waddr},  {28'd0, exp_waddr});
    checkOutput({tag, ".rf_wdata"},  rf_wdata,           exp_wdata);
    checkOutput({tag, ".pc_wdata"},  pc_wdata,           exp_pc_wdata);
    checkOutput({tag, ".busy"},      {31'd0, busy},      {31'd0, cur_valid});
    checkOutput({tag, ".res_ready"}, {31'd0, res_ready}, {31'd0, !cur_valid});
  endtask

  // Drive one cycle of inputs (called at a falling edge), clock it, then check.
  task automatic applyStimulus(input string tag, input logic v, input logic [1:0] d,
                               input logic [31:0] lo, input logic [31:0] hi,
                               input logic [3:0] rl, input logic [3:0] rh, output logic accepted);
    res_valid = v; res_dst = d; res_lo = lo; res_hi = hi; rd_lo = rl; rd_hi = rh;
    accepted = v && !cur_valid;
    @(posedge clk);
    model_edge(accepted, d, lo, hi, rl, rh);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle_cycle(input string tag);
    logic a;
    applyStimulus(tag, 1'b0, 2'b00, $urandom, $urandom, 4'($urandom), 4'($urandom), a);
  endtask

  initial begin
    logic        acc;
    logic [1:0]  q_dst[3];
    logic [31:0] q_lo[3];
    logic [3:0]  q_rd[3];
    int          idx;
    int          guard;

    res_valid = 1'b0; res_dst = 2'b00; res_lo = '0; res_hi = '0; rd_lo = '0; rd_hi = '0;
    rst = 1'b1;
    model_reset();
    cur = '{1'b0, 4'd0, 32'd0};
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    idle_cycle("post_reset");

    applyStimulus("t1_single", 1'b1, 2'b00, 32'hDEADBEEF, 32'h0, 4'd3, 4'd0, acc);
    idle_cycle("t1_done");

    applyStimulus("t2_lo", 1'b1, 2'b01, 32'h1, 32'h2, 4'd4, 4'd5, acc);
    idle_cycle("t2_hi");
    idle_cycle("t2_done");

    applyStimulus("t3_r15", 1'b1, 2'b00, 32'h100, 32'h0, 4'd15, 4'd0, acc);
    idle_cycle("t3_r15_done");
    applyStimulus("t3_pc", 1'b1, 2'b10, 32'h200, 32'h0, 4'd1, 4'd0, acc);
    idle_cycle("t3_pc_done");

    applyStimulus("t4_discard", 1'b1, 2'b11, 32'h77, 32'h0, 4'd9, 4'd0, acc);
    applyStimulus("t4_write", 1'b1, 2'b00, 32'h55, 32'h0, 4'd2, 4'd0, acc);
    idle_cycle("t4_done");

    applyStimulus("t5_same_lo", 1'b1, 2'b01, 32'hA, 32'hB, 4'd6, 4'd6, acc);
    idle_cycle("t5_same_hi");
    idle_cycle("t5_same_done");

    applyStimulus("t5_rst_lo", 1'b1, 2'b01, 32'h11, 32'h22, 4'd7, 4'd8, acc);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("t5_async_rst");
    @(negedge clk);
    rst = 1'b0;
    idle_cycle("t5_after_rst");
    idle_cycle("t5_no_hi");

    q_dst[0] = 2'b00; q_lo[0] = 32'hA0A0_0001; q_rd[0] = 4'd1;
    q_dst[1] = 2'b01; q_lo[1] = 32'hA0A0_0002; q_rd[1] = 4'd2;
    q_dst[2] = 2'b10; q_lo[2] = 32'hA0A0_0003; q_rd[2] = 4'd3;
    idx = 0;
    guard = 0;
    while (idx < 3 && guard < 20) begin
      applyStimulus("t6_queue", 1'b1, q_dst[idx], q_lo[idx], q_lo[idx] ^ 32'hFFFF, q_rd[idx], 4'd12, acc);
      if (acc) idx++;
      guard++;
    end
    checks_total++;
    assert (idx == 3) checks_passed++;
    else $error("[TB] FAIL t6_accept_count observed=%0d expected=3", idx);
    repeat (3) idle_cycle("t6_drain");

    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", ($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom,
                    4'($urandom), 4'($urandom), acc);
    end
    repeat (3) idle_cycle("rand_drain");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
